// File: rtl/dds_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dds_ctrl_pkg
// Shared definitions for the DDS control blocks: state encoding for the sweep
// sequencer and the default datapath widths, so that future DDS hop or
// arbitration controllers can reuse the same encoding and sizes.
// No ports (package).
// -----------------------------------------------------------------------------
package dds_ctrl_pkg;

  // Default widths
  localparam int DDS_ACC_W = 32;  // phase accumulator / increment width
  localparam int DDS_PH_W  = 8;   // phase offset width
  localparam int DDS_CNT_W = 16;  // step-count and dwell counter width

  // State encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ARM  = ST_ARM,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } dds_state_e;

endpackage : dds_ctrl_pkg

// File: rtl/dds_step_timer.sv
// -----------------------------------------------------------------------------
// dds_step_timer
// Dwell and step counters for the sweep sequencer.
//   dwell_cnt counts the cycles spent on the current frequency (0..D).
//   step_idx  counts the frequency index within the sweep (0..N).
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   clr_i            : force both counters to zero (outside RUN, or on abort)
//   run_i            : advance the counters this cycle
//   repeat_i         : wrap step_idx to 0 after the last step instead of holding
//   dwell_i          : D, last dwell count of each frequency
//   n_steps_i        : N, last step index of the sweep
//   dwell_tc_o       : dwell_cnt == D (current frequency ends this cycle)
//   step_tc_o        : step_idx  == N (current frequency is the last one)
// -----------------------------------------------------------------------------
module dds_step_timer
  import dds_ctrl_pkg::*;
#(
  parameter int CNT_W = DDS_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             run_i,
  input  logic             repeat_i,
  input  logic [CNT_W-1:0] dwell_i,
  input  logic [CNT_W-1:0] n_steps_i,
  output logic             dwell_tc_o,
  output logic             step_tc_o
);

  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [CNT_W-1:0] step_idx_q,  step_idx_d;

  always_comb begin
    dwell_tc_o  = (dwell_cnt_q == dwell_i);
    step_tc_o   = (step_idx_q == n_steps_i);
    dwell_cnt_d = dwell_cnt_q;
    step_idx_d  = step_idx_q;
    if (clr_i) begin
      dwell_cnt_d = '0;
      step_idx_d  = '0;
    end else if (run_i) begin
      if (dwell_tc_o) begin
        dwell_cnt_d = '0;
        if (!step_tc_o) begin
          step_idx_d = step_idx_q + 1'b1;
        end else if (repeat_i) begin
          step_idx_d = '0;
        end
        // Last step without repeat: the sequencer leaves RUN, value is don't-care.
      end else begin
        dwell_cnt_d = dwell_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dwell_cnt_q <= '0;
      step_idx_q  <= '0;
    end else begin
      dwell_cnt_q <= dwell_cnt_d;
      step_idx_q  <= step_idx_d;
    end
  end

endmodule : dds_step_timer

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
// Stepped-frequency sweep sequencer driving the DDS tuning inputs.
// A sweep visits N+1 frequencies f_start + k*f_step (k = 0..N, modulo 2^ACC_W),
// each held D+1 cycles, optionally repeating until abort.
//
// Request semantics: start and abort are single-cycle, level-sampled requests
// with no ready/acknowledge. start is honoured only in IDLE and only when abort
// is low; start while busy is dropped, not queued. abort returns to IDLE from
// any state on the next edge and wins over start.
//
// Ports:
//   clock, reset_n  : clock, asynchronous active-low reset
//   start, abort    : sweep requests (see above)
//   cfg_f_start     : first increment value
//   cfg_f_step      : signed per-step increment delta
//   cfg_n_steps     : N (sweep has N+1 frequencies)
//   cfg_dwell       : D (each frequency held D+1 cycles)
//   cfg_repeat      : restart at f_start after the last frequency
//   cfg_phase       : phase offset for the DDS
//   increment       : DDS phase increment
//   phase           : DDS phase offset
//   dds_reset       : DDS accumulator reset, active high
//   busy            : high in ARM/RUN/DONE
//   step_strobe     : one-cycle pulse when increment moves to a new step
//   done            : one-cycle pulse on normal completion
//   dbg_state       : current FSM state encoding, for observation only
// All outputs are registered. cfg_* is captured on the accepting start edge.
// -----------------------------------------------------------------------------
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int ACC_W = DDS_ACC_W,
  parameter int PH_W  = DDS_PH_W,
  parameter int CNT_W = DDS_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ACC_W-1:0] cfg_f_start,
  input  logic [ACC_W-1:0] cfg_f_step,
  input  logic [CNT_W-1:0] cfg_n_steps,
  input  logic [CNT_W-1:0] cfg_dwell,
  input  logic             cfg_repeat,
  input  logic [PH_W-1:0]  cfg_phase,
  output logic [ACC_W-1:0] increment,
  output logic [PH_W-1:0]  phase,
  output logic             dds_reset,
  output logic             busy,
  output logic             step_strobe,
  output logic             done,
  output logic [1:0]       dbg_state
);

  dds_state_e       state_q;

  // Configuration captured at start
  logic [ACC_W-1:0] f_start_q;
  logic [ACC_W-1:0] f_step_q;
  logic [CNT_W-1:0] n_steps_q;
  logic [CNT_W-1:0] dwell_q;
  logic             repeat_q;

  logic             dwell_tc;
  logic             step_tc;
  logic             timer_clr;
  logic             timer_run;

  // Counters restart from zero on every entry to RUN; clearing on abort keeps
  // them at zero throughout IDLE.
  assign timer_clr = (state_q != RUN) || abort;
  assign timer_run = (state_q == RUN);

  dds_step_timer #(
    .CNT_W (CNT_W)
  ) u_step_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clr_i      (timer_clr),
    .run_i      (timer_run),
    .repeat_i   (repeat_q),
    .dwell_i    (dwell_q),
    .n_steps_i  (n_steps_q),
    .dwell_tc_o (dwell_tc),
    .step_tc_o  (step_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      increment   <= '0;
      phase       <= '0;
      dds_reset   <= 1'b1;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      f_start_q   <= '0;
      f_step_q    <= '0;
      n_steps_q   <= '0;
      dwell_q     <= '0;
      repeat_q    <= 1'b0;
    end else begin
      // Pulses default low every cycle
      step_strobe <= 1'b0;
      done        <= 1'b0;

      if (abort) begin
        // Abort from any state: IDLE outputs on the next edge, no pulses.
        state_q   <= IDLE;
        increment <= '0;
        phase     <= '0;
        dds_reset <= 1'b1;
        busy      <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            increment <= '0;
            phase     <= '0;
            dds_reset <= 1'b1;
            busy      <= 1'b0;
            if (start) begin
              f_start_q <= cfg_f_start;
              f_step_q  <= cfg_f_step;
              n_steps_q <= cfg_n_steps;
              dwell_q   <= cfg_dwell;
              repeat_q  <= cfg_repeat;
              increment <= cfg_f_start;
              phase     <= cfg_phase;
              busy      <= 1'b1;
              state_q   <= ARM;
            end
          end

          ARM: begin
            // dds_reset stays high through ARM to clear the DDS accumulator.
            dds_reset <= 1'b0;
            state_q   <= RUN;
          end

          RUN: begin
            if (dwell_tc) begin
              if (!step_tc) begin
                increment   <= increment + f_step_q;  // wraps modulo 2^ACC_W
                step_strobe <= 1'b1;
              end else if (repeat_q) begin
                increment   <= f_start_q;
                step_strobe <= 1'b1;
              end else begin
                done    <= 1'b1;
                state_q <= DONE;
              end
            end
          end

          DONE: begin
            increment <= '0;
            phase     <= '0;
            dds_reset <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign dbg_state = state_q;

endmodule : dds_sweep_ctrl
